// File: rtl/jtframe_rom_pkg.sv
// Shared types and helpers for the N-slot SDRAM ROM arbiter.
package jtframe_rom_pkg;

  localparam int SDRAM_AW  = 22;
  localparam int SDRAM_DW  = 32;
  localparam int MAX_SLOTS = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } rom_state_t;

  // Pull the SDRAM word offset of slot idx out of the packed offset vector
  function automatic logic [SDRAM_AW-1:0] slot_offset(
    input logic [MAX_SLOTS*SDRAM_AW-1:0] offsets,
    input int                            idx
  );
    return offsets[SDRAM_AW*idx +: SDRAM_AW];
  endfunction

endpackage

// File: rtl/jtframe_rom_nslot_cache.sv
// One-word (32-bit) cache for a single ROM slot: tag/valid/data storage,
// live-address hit compare and byte/word selection of the cached word.
module jtframe_rom_nslot_cache
  import jtframe_rom_pkg::*;
#(
  parameter int AW   = 18,
  parameter bit DW16 = 1'b0
)(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic                cs,
  input  logic [AW-1:0]       addr,
  input  logic                we,
  input  logic [AW-2:0]       wr_tag,
  input  logic [SDRAM_DW-1:0] wr_data,
  output logic [AW-2:0]       live_tag,
  output logic                hit,
  output logic [15:0]         dout
);

  logic                valid;
  logic [AW-2:0]       tag;
  logic [SDRAM_DW-1:0] data;

  // Tag of the live address; 8-bit slots zero-extend so both widths share storage
  always_comb begin
    if (DW16) live_tag = addr[AW-1:1];
    else      live_tag = {1'b0, addr[AW-1:2]};
  end

  // Select the addressed byte or half-word of the cached 32-bit word
  always_comb begin
    dout = '0;
    if (DW16) begin
      dout = addr[0] ? data[31:16] : data[15:0];
    end else begin
      case (addr[1:0])
        2'd0:    dout[7:0] = data[7:0];
        2'd1:    dout[7:0] = data[15:8];
        2'd2:    dout[7:0] = data[23:16];
        default: dout[7:0] = data[31:24];
      endcase
    end
  end

  // Cache line storage: a flush only drops valid, a fill writes the whole line
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      tag   <= '0;
      data  <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (we) begin
      valid <= 1'b1;
      tag   <= wr_tag;
      data  <= wr_data;
    end
  end

  assign hit = cs & valid & (tag == live_tag);

endmodule

// File: rtl/jtframe_rom_nslot.sv
// N-slot SDRAM ROM arbiter. Each slot owns a one-word cache; misses are
// serialised onto one SDRAM req/ack/data_rdy handshake.
// Build option: JTFRAME_ROM_RR_EN selects round-robin arbitration,
// otherwise the highest pending slot index wins.
module jtframe_rom_nslot
  import jtframe_rom_pkg::*;
#(
  parameter int               SLOTS   = 4,
  parameter int               AW      = 18,
  parameter logic [SLOTS-1:0] DW16    = '0,
  parameter logic [SLOTS*22-1:0] OFFSETS = '0
)(
  input  logic                clk,
  input  logic                rst_n,
  input  logic [SLOTS-1:0]    slot_cs,
  input  logic [SLOTS*AW-1:0] slot_addr,
  output logic [SLOTS-1:0]    slot_ok,
  output logic [SLOTS*16-1:0] slot_dout,
  input  logic                downloading,
  input  logic                loop_rst,
  output logic                sdram_req,
  input  logic                sdram_ack,
  output logic [SDRAM_AW-1:0] sdram_addr,
  input  logic                data_rdy,
  input  logic [SDRAM_DW-1:0] data_read,
  output logic                refresh_en
);

  localparam int IW = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam int TW = AW - 1;
  localparam logic [MAX_SLOTS*SDRAM_AW-1:0] OFF_ALL = (MAX_SLOTS*SDRAM_AW)'(OFFSETS);

  rom_state_t          state, state_nx;
  logic                flush;
  logic [SLOTS-1:0]    hit;
  logic [SLOTS-1:0]    pend;
  logic [TW-1:0]       live_tag [SLOTS];
  logic [SDRAM_AW-1:0] req_addr [SLOTS];
  logic [IW-1:0]       win, win_nx;
  logic [TW-1:0]       lat_tag;
  logic                latch, fill;

  assign flush   = downloading | loop_rst;
  assign pend    = slot_cs & ~hit;
  assign slot_ok = hit & {SLOTS{~flush}};

  genvar g;
  for (g = 0; g < SLOTS; g++) begin : g_slot
    logic we;
    assign we = fill && (win == IW'(g));

    jtframe_rom_nslot_cache #(
      .AW   (AW),
      .DW16 (DW16[g])
    ) u_cache (
      .clk      (clk),
      .rst_n    (rst_n),
      .flush    (flush),
      .cs       (slot_cs[g]),
      .addr     (slot_addr[g*AW +: AW]),
      .we       (we),
      .wr_tag   (lat_tag),
      .wr_data  (data_read),
      .live_tag (live_tag[g]),
      .hit      (hit[g]),
      .dout     (slot_dout[g*16 +: 16])
    );

    assign req_addr[g] = slot_offset(OFF_ALL, g) + SDRAM_AW'({live_tag[g], 1'b0});
  end

`ifdef JTFRAME_ROM_RR_EN
  logic [IW-1:0] last_winner;
  logic [IW-1:0] rr_idx;
  logic          rr_found;

  // Round-robin pick: first pending slot searching from last_winner+1
  always_comb begin
    win_nx   = '0;
    rr_idx   = '0;
    rr_found = 1'b0;
    for (int k = 0; k < SLOTS; k++) begin
      rr_idx = IW'((int'(last_winner) + 1 + k) % SLOTS);
      if (!rr_found && pend[rr_idx]) begin
        win_nx   = rr_idx;
        rr_found = 1'b1;
      end
    end
  end

  // Rotate the search start only when a transaction actually completes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    last_winner <= IW'(SLOTS - 1);
    else if (fill) last_winner <= win;
  end
`else
  // Fixed priority pick: the highest pending slot index wins
  always_comb begin
    win_nx = '0;
    for (int k = 0; k < SLOTS; k++) begin
      if (pend[IW'(k)]) win_nx = IW'(k);
    end
  end
`endif

  // Next state and handshake outputs; reset and flush force a quiet bus
  always_comb begin
    state_nx   = state;
    latch      = 1'b0;
    fill       = 1'b0;
    sdram_req  = 1'b0;
    refresh_en = 1'b0;
    if (flush || !rst_n) begin
      state_nx   = IDLE;
      refresh_en = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (|pend) begin
            latch    = 1'b1;
            state_nx = REQ;
          end else begin
            refresh_en = 1'b1;
          end
        end
        REQ: begin
          sdram_req = 1'b1;
          if (sdram_ack) state_nx = WAIT;
        end
        WAIT: begin
          if (data_rdy) begin
            fill     = 1'b1;
            state_nx = IDLE;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Commit winner, SDRAM address and tag when a transaction is launched
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win        <= '0;
      sdram_addr <= '0;
      lat_tag    <= '0;
    end else if (latch) begin
      win        <= win_nx;
      sdram_addr <= req_addr[win_nx];
      lat_tag    <= live_tag[win_nx];
    end
  end

endmodule

// File: tb/tb_jtframe_rom_nslot.sv
// Self-checking bench for jtframe_rom_nslot: transaction-level reference
// model compared every cycle, plus directed literal expectations.
module tb_jtframe_rom_nslot;

  localparam int SLOTS = 4;
  localparam int AW    = 18;
  localparam logic [SLOTS-1:0]    DW16    = 4'b0010;
  localparam logic [SLOTS*22-1:0] OFFSETS = {22'h080000, 22'h030000, 22'h020000, 22'h010000};
  localparam int OFF_TBL [SLOTS] = '{32'h010000, 32'h020000, 32'h030000, 32'h080000};

  logic                clk = 1'b0;
  logic                rst_n;
  logic [SLOTS-1:0]    slot_cs;
  logic [SLOTS*AW-1:0] slot_addr;
  logic [SLOTS-1:0]    slot_ok;
  logic [SLOTS*16-1:0] slot_dout;
  logic                downloading;
  logic                loop_rst;
  logic                sdram_req;
  logic                sdram_ack;
  logic [21:0]         sdram_addr;
  logic                data_rdy;
  logic [31:0]         data_read;
  logic                refresh_en;

  int checks = 0;
  int errors = 0;

  jtframe_rom_nslot #(
    .SLOTS   (SLOTS),
    .AW      (AW),
    .DW16    (DW16),
    .OFFSETS (OFFSETS)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .slot_cs     (slot_cs),
    .slot_addr   (slot_addr),
    .slot_ok     (slot_ok),
    .slot_dout   (slot_dout),
    .downloading (downloading),
    .loop_rst    (loop_rst),
    .sdram_req   (sdram_req),
    .sdram_ack   (sdram_ack),
    .sdram_addr  (sdram_addr),
    .data_rdy    (data_rdy),
    .data_read   (data_read),
    .refresh_en  (refresh_en)
  );

  always #5 clk = ~clk;

  // Reference model: per-slot cached line plus one outstanding transaction
  logic        m_valid [SLOTS];
  int          m_tag   [SLOTS];
  logic [31:0] m_data  [SLOTS];
  logic        m_busy  = 1'b0;
  logic        m_acked = 1'b0;
  int          m_win   = 0;
  int          m_tagl  = 0;
  logic [21:0] m_addr  = '0;
`ifdef JTFRAME_ROM_RR_EN
  int          m_last  = SLOTS - 1;
`endif

  function automatic logic [AW-1:0] addr_of(input int i);
    return slot_addr[i*AW +: AW];
  endfunction

  function automatic int tag_of(input int i, input logic [AW-1:0] a);
    return DW16[i] ? int'(a >> 1) : int'(a >> 2);
  endfunction

  function automatic logic [21:0] map_addr(input int i);
    return 22'((OFF_TBL[i] + 2 * tag_of(i, addr_of(i))) & 32'h3FFFFF);
  endfunction

  function automatic logic cached(input int i);
    return m_valid[i] && (m_tag[i] == tag_of(i, addr_of(i)));
  endfunction

  function automatic logic pending(input int i);
    return slot_cs[i] && !cached(i);
  endfunction

  function automatic int pick_winner();
    int w = -1;
`ifdef JTFRAME_ROM_RR_EN
    for (int k = SLOTS; k >= 1; k--) begin
      int j = (m_last + k) % SLOTS;
      if (pending(j)) w = j;
    end
`else
    for (int i = 0; i < SLOTS; i++) if (pending(i)) w = i;
`endif
    return w;
  endfunction

  function automatic logic [15:0] exp_dout(input int i);
    logic [31:0]   d;
    logic [AW-1:0] a;
    d = m_data[i];
    a = addr_of(i);
    if (DW16[i]) return a[0] ? d[31:16] : d[15:0];
    return 16'((d >> (8 * int'(a[1:0]))) & 32'h0000_00FF);
  endfunction

  // Advance the model on the same edges the design sees
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SLOTS; i++) begin
        m_valid[i] <= 1'b0;
        m_tag[i]   <= 0;
        m_data[i]  <= '0;
      end
      m_busy  <= 1'b0;
      m_acked <= 1'b0;
`ifdef JTFRAME_ROM_RR_EN
      m_last  <= SLOTS - 1;
`endif
    end else if (downloading || loop_rst) begin
      for (int i = 0; i < SLOTS; i++) m_valid[i] <= 1'b0;
      m_busy  <= 1'b0;
      m_acked <= 1'b0;
    end else if (!m_busy) begin
      if (pick_winner() >= 0) begin
        m_busy  <= 1'b1;
        m_acked <= 1'b0;
        m_win   <= pick_winner();
        m_addr  <= map_addr(pick_winner());
        m_tagl  <= tag_of(pick_winner(), addr_of(pick_winner()));
      end
    end else if (!m_acked) begin
      if (sdram_ack) m_acked <= 1'b1;
    end else if (data_rdy) begin
      m_valid[m_win] <= 1'b1;
      m_tag[m_win]   <= m_tagl;
      m_data[m_win]  <= data_read;
      m_busy         <= 1'b0;
`ifdef JTFRAME_ROM_RR_EN
      m_last         <= m_win;
`endif
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h t=%0t", name, actual, expected, $time);
    end
  endtask

  task automatic compare_model();
    logic                fl;
    logic                anyp;
    logic                er;
    logic [SLOTS-1:0]    eo;
    logic [SLOTS*16-1:0] ed;
    fl   = downloading | loop_rst;
    anyp = 1'b0;
    eo   = '0;
    ed   = '0;
    for (int i = 0; i < SLOTS; i++) begin
      if (pending(i)) anyp = 1'b1;
      eo[i] = rst_n && !fl && slot_cs[i] && cached(i);
      ed[i*16 +: 16] = exp_dout(i);
    end
    er = rst_n && !fl && m_busy && !m_acked;
    checkOutput("cmp slot_ok", 64'(slot_ok), 64'(eo));
    checkOutput("cmp slot_dout", 64'(slot_dout), 64'(ed));
    checkOutput("cmp sdram_req", 64'(sdram_req), 64'(er));
    checkOutput("cmp refresh_en", 64'(refresh_en), 64'(!rst_n || fl || (!m_busy && !anyp)));
    if (er) checkOutput("cmp sdram_addr", 64'(sdram_addr), 64'(m_addr));
  endtask

  always @(negedge clk) compare_model();

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input int slot, input logic cs, input logic [AW-1:0] a);
    slot_cs[slot] = cs;
    slot_addr[slot*AW +: AW] = a;
  endtask

  // Wait a bounded time for sdram_req and check the requested address
  task automatic waitReq(input string name, input logic [21:0] exp_addr, output logic seen);
    int n = 0;
    while (!sdram_req && n < 20) begin
      step();
      n++;
    end
    seen = sdram_req;
    checkOutput({name, " req"}, 64'(sdram_req), 64'd1);
    if (seen) checkOutput({name, " addr"}, 64'(sdram_addr), 64'(exp_addr));
  endtask

  // Complete one SDRAM transaction; optionally drop a slot's cs while in WAIT
  task automatic serve(input string name, input logic [21:0] exp_addr, input logic [31:0] data, input int drop);
    logic seen;
    waitReq(name, exp_addr, seen);
    if (!seen) return;
    sdram_ack = 1'b1;
    step();
    sdram_ack = 1'b0;
    if (drop >= 0) slot_cs[drop] = 1'b0;
    step();
    data_read = data;
    data_rdy  = 1'b1;
    step();
    data_rdy  = 1'b0;
    data_read = '0;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic        seen;
    logic [21:0] a_first, a_second;
    logic [31:0] d_first, d_second;

    rst_n       = 1'b0;
    slot_cs     = '0;
    slot_addr   = '0;
    downloading = 1'b0;
    loop_rst    = 1'b0;
    sdram_ack   = 1'b0;
    data_rdy    = 1'b0;
    data_read   = '0;

    repeat (3) @(posedge clk);
    #2;
    checkOutput("reset sdram_req", 64'(sdram_req), 64'd0);
    checkOutput("reset refresh_en", 64'(refresh_en), 64'd1);
    checkOutput("reset slot_ok", 64'(slot_ok), 64'd0);
    checkOutput("reset slot_dout", 64'(slot_dout), 64'd0);
    checkOutput("reset sdram_addr", 64'(sdram_addr), 64'd0);
    step();
    rst_n = 1'b1;
    step();

    $display("[TB] 8-bit slot 0 miss then same-word hit");
    applyStimulus(0, 1'b1, 18'h00005);
    serve("t1", 22'h010002, 32'hDDCCBBAA, -1);
    #1;
    checkOutput("t1 ok", 64'(slot_ok[0]), 64'd1);
    checkOutput("t1 dout", 64'(slot_dout[15:0]), 64'h00BB);
    applyStimulus(0, 1'b1, 18'h00006);
    #1;
    checkOutput("t1 hit ok", 64'(slot_ok[0]), 64'd1);
    checkOutput("t1 hit dout", 64'(slot_dout[15:0]), 64'h00CC);
    checkOutput("t1 hit no req", 64'(sdram_req), 64'd0);
    step();
    checkOutput("t1 still no req", 64'(sdram_req), 64'd0);

    $display("[TB] 16-bit slot 1 word select");
    applyStimulus(1, 1'b1, 18'h00003);
    serve("t2", 22'h020002, 32'h56781234, -1);
    #1;
    checkOutput("t2 ok", 64'(slot_ok[1]), 64'd1);
    checkOutput("t2 dout hi", 64'(slot_dout[31:16]), 64'h5678);
    applyStimulus(1, 1'b1, 18'h00002);
    #1;
    checkOutput("t2 hit ok", 64'(slot_ok[1]), 64'd1);
    checkOutput("t2 dout lo", 64'(slot_dout[31:16]), 64'h1234);
    checkOutput("t2 hit no req", 64'(sdram_req), 64'd0);
    step();

    $display("[TB] slot 3 alone, then slots 0 and 3 miss together");
    applyStimulus(3, 1'b1, 18'h00000);
    serve("t3a", 22'h080000, 32'hA0A1A2A3, -1);
    #1;
    checkOutput("t3a dout", 64'(slot_dout[63:48]), 64'h00A3);
    applyStimulus(0, 1'b1, 18'h00040);
    applyStimulus(3, 1'b1, 18'h00008);
`ifdef JTFRAME_ROM_RR_EN
    a_first = 22'h010020; d_first = 32'h00000055;
    a_second = 22'h080004; d_second = 32'h00000077;
`else
    a_first = 22'h080004; d_first = 32'h00000077;
    a_second = 22'h010020; d_second = 32'h00000055;
`endif
    serve("t3 first", a_first, d_first, -1);
    checkOutput("t3 gap idle", 64'(sdram_req), 64'd0);
    step();
    checkOutput("t3 b2b req", 64'(sdram_req), 64'd1);
    serve("t3 second", a_second, d_second, -1);
    #1;
    checkOutput("t3 ok", 64'(slot_ok & 4'b1001), 64'(4'b1001));
    checkOutput("t3 dout0", 64'(slot_dout[15:0]), 64'h0055);
    checkOutput("t3 dout3", 64'(slot_dout[63:48]), 64'h0077);
    step();

    $display("[TB] cs dropped during WAIT still fills the cache");
    applyStimulus(2, 1'b1, 18'h00010);
    serve("t4", 22'h030008, 32'h11223344, 2);
    applyStimulus(2, 1'b1, 18'h00010);
    #1;
    checkOutput("t4 ok", 64'(slot_ok[2]), 64'd1);
    checkOutput("t4 dout", 64'(slot_dout[47:32]), 64'h0044);
    checkOutput("t4 no req", 64'(sdram_req), 64'd0);
    step();
    checkOutput("t4 still no req", 64'(sdram_req), 64'd0);

    $display("[TB] downloading pulse abandons WAIT and clears the caches");
    applyStimulus(0, 1'b1, 18'h00080);
    waitReq("t5", 22'h010040, seen);
    sdram_ack = 1'b1;
    step();
    sdram_ack = 1'b0;
    downloading = 1'b1;
    #1;
    checkOutput("t5 dl req", 64'(sdram_req), 64'd0);
    checkOutput("t5 dl ok", 64'(slot_ok), 64'd0);
    checkOutput("t5 dl refresh", 64'(refresh_en), 64'd1);
    step();
    downloading = 1'b0;
    data_read = 32'hDEADBEEF;
    data_rdy  = 1'b1;
    step();
    data_rdy  = 1'b0;
    data_read = '0;
    checkOutput("t5 hits now miss", 64'(slot_ok), 64'd0);
    checkOutput("t5 new req", 64'(sdram_req), 64'd1);
    checkOutput("t5 new addr", 64'(sdram_addr), 64'h080004);

    $display("[TB] asynchronous reset during REQ");
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("t6 async req", 64'(sdram_req), 64'd0);
    checkOutput("t6 refresh", 64'(refresh_en), 64'd1);
    checkOutput("t6 ok", 64'(slot_ok), 64'd0);
    checkOutput("t6 dout", 64'(slot_dout), 64'd0);
    step();
    checkOutput("t6 held addr", 64'(sdram_addr), 64'd0);
    slot_cs = '0;
    step();
    checkOutput("t6 held req", 64'(sdram_req), 64'd0);
    rst_n = 1'b1;
    step();
    checkOutput("t6 after release", 64'(sdram_req), 64'd0);

    $display("[TB] loop_rst flush");
    applyStimulus(1, 1'b1, 18'h00002);
    serve("t7", 22'h020002, 32'hCAFE0001, -1);
    #1;
    checkOutput("t7 ok", 64'(slot_ok[1]), 64'd1);
    checkOutput("t7 dout", 64'(slot_dout[31:16]), 64'h0001);
    loop_rst = 1'b1;
    #1;
    checkOutput("t7 flush ok", 64'(slot_ok[1]), 64'd0);
    step();
    loop_rst = 1'b0;
    #1;
    checkOutput("t7 after flush", 64'(slot_ok[1]), 64'd0);
    slot_cs = '0;
    repeat (3) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
